// File: rtl/pcie_fifo_burst_reader.sv
// Read-side burst controller for pcie_fifo: requests a DMA burst once enough words are
// buffered, then drains exactly the granted count onto a valid/ready stream via a 2-entry skid buffer.
module pcie_fifo_burst_reader #(
  parameter int DATA_WIDTH  = 128,
  parameter int LEVEL_WIDTH = 10,
  parameter int BURST_LEN   = 16,
  parameter int LEN_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   tb_rst,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
  output logic                   fifo_rd_en,
  input  logic                   flush,
  output logic                   burst_req,
  output logic [LEN_WIDTH-1:0]   burst_len,
  input  logic                   burst_ack,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  localparam logic [LEVEL_WIDTH-1:0] FULL_LEVEL = LEVEL_WIDTH'(BURST_LEN);
  localparam logic [LEN_WIDTH-1:0]   FULL_LEN   = LEN_WIDTH'(BURST_LEN);

  state_t                 state_p0, state_nxt;
  logic [LEN_WIDTH-1:0]   len_p0, len_nxt;
  logic [LEN_WIDTH-1:0]   rd_cnt_p0, beat_cnt_p0;
  logic                   vld_p1;
  logic [DATA_WIDTH-1:0]  buf0_p2, buf1_p2;
  logic [1:0]             buf_cnt_p2;
  logic [2:0]             occ_after;
  logic                   pop, last_pop;

  assign m_valid   = (buf_cnt_p2 != 2'd0);
  assign m_data    = buf0_p2;
  assign pop       = m_valid && m_ready;
  assign m_last    = m_valid && (beat_cnt_p0 == len_p0 - LEN_WIDTH'(1));
  assign last_pop  = pop && m_last;
  assign burst_req = (state_p0 == REQ);
  assign burst_len = len_p0;
  assign busy      = (state_p0 != IDLE);

  // Occupancy the skid buffer will have once the in-flight word lands and any pop retires.
  assign occ_after  = 3'(buf_cnt_p2) + 3'(vld_p1) - 3'(pop);
  assign fifo_rd_en = (state_p0 == XFER) && (rd_cnt_p0 < len_p0) &&
                      !fifo_rd_empty && (occ_after < 3'd2);

  always_comb begin
    state_nxt = state_p0;
    len_nxt   = len_p0;
    case (state_p0)
      IDLE: begin
        if (fifo_rd_water_level >= FULL_LEVEL) begin
          state_nxt = REQ;
          len_nxt   = FULL_LEN;
        end else if (flush && (fifo_rd_water_level != '0)) begin
          state_nxt = REQ;
          len_nxt   = LEN_WIDTH'(fifo_rd_water_level);
        end
      end
      REQ:     if (burst_ack) state_nxt = XFER;
      XFER:    if (last_pop)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: control state and burst counters
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state_p0    <= IDLE;
      len_p0      <= '0;
      rd_cnt_p0   <= '0;
      beat_cnt_p0 <= '0;
    end else begin
      state_p0 <= state_nxt;
      if (state_p0 == IDLE) len_p0 <= len_nxt;
      if (last_pop) begin
        rd_cnt_p0   <= '0;
        beat_cnt_p0 <= '0;
      end else begin
        if (fifo_rd_en) rd_cnt_p0   <= rd_cnt_p0 + LEN_WIDTH'(1);
        if (pop)        beat_cnt_p0 <= beat_cnt_p0 + LEN_WIDTH'(1);
      end
    end
  end

  // Stage p1/p2: read in flight, then capture into the skid buffer
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      vld_p1     <= 1'b0;
      buf0_p2    <= '0;
      buf1_p2    <= '0;
      buf_cnt_p2 <= 2'd0;
    end else begin
      vld_p1 <= fifo_rd_en;
      case ({vld_p1, pop})
        2'b10: begin
          if (buf_cnt_p2 == 2'd0) buf0_p2 <= fifo_rd_data;
          else                    buf1_p2 <= fifo_rd_data;
          buf_cnt_p2 <= buf_cnt_p2 + 2'd1;
        end
        2'b01: begin
          buf0_p2    <= buf1_p2;
          buf_cnt_p2 <= buf_cnt_p2 - 2'd1;
        end
        2'b11: begin
          if (buf_cnt_p2 == 2'd2) begin
            buf0_p2 <= buf1_p2;
            buf1_p2 <= fifo_rd_data;
          end else begin
            buf0_p2 <= fifo_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_fifo_burst_reader.sv
// Bench for pcie_fifo_burst_reader: a queue-based FIFO model feeds the DUT; a table of bursts
// plus hand-written sequences cover reset, flush, multi-burst and empty stalls.
module tb_pcie_fifo_burst_reader;
  localparam int DW = 128, LW = 10, BL = 16, LNW = 8;

  logic           clk = 1'b0;
  logic           tb_rst;
  logic [DW-1:0]  fifo_rd_data;
  logic           fifo_rd_empty;
  logic [LW-1:0]  fifo_rd_water_level;
  logic           fifo_rd_en;
  logic           flush;
  logic           burst_req;
  logic [LNW-1:0] burst_len;
  logic           burst_ack;
  logic [DW-1:0]  m_data;
  logic           m_valid;
  logic           m_ready;
  logic           m_last;
  logic           busy;

  always #5 clk = ~clk;

  pcie_fifo_burst_reader #(.DATA_WIDTH(DW), .LEVEL_WIDTH(LW), .BURST_LEN(BL), .LEN_WIDTH(LNW)) dut (
    .clk(clk), .tb_rst(tb_rst), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_water_level(fifo_rd_water_level), .fifo_rd_en(fifo_rd_en), .flush(flush),
    .burst_req(burst_req), .burst_len(burst_len), .burst_ack(burst_ack), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .busy(busy)
  );

  typedef struct {int n; logic fl; int mode; int exp_len;} vec_t;
  vec_t tbl[5];

  int checks = 0, failures = 0;
  logic [DW-1:0] q[$], expq[$];
  logic force_empty;
  int seq_n = 0, cur_cyc = 0, rd_total = 0, pop_total = 0, beat_idx = 0, cur_len = 0;
  int last_pop_c = 0, req_c = 0;
  logic s_req, s_rd_en, s_valid, s_pop, s_last, s_busy;
  logic [DW-1:0] s_data, prev_data;
  logic [LNW-1:0] s_len;
  logic prev_stall = 1'b0, prev_last = 1'b0;

  function automatic logic [DW-1:0] word(input int k);
    return {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF - 32'(k)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=expired required=event", name);
  endtask

  task automatic update_if();
    fifo_rd_water_level = LW'(q.size());
    fifo_rd_empty = (q.size() == 0) || force_empty;
  endtask

  task automatic preload(input int n);
    for (int i = 0; i < n; i++) begin
      q.push_back(word(seq_n));
      expq.push_back(word(seq_n));
      seq_n++;
    end
    update_if();
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_rd_en"}, int'(fifo_rd_en), 0);
    chk({tag, "_req"},   int'(burst_req), 0);
    chk({tag, "_len"},   int'(burst_len), 0);
    chk({tag, "_valid"}, int'(m_valid), 0);
    chk({tag, "_last"},  int'(m_last), 0);
    chk_w({tag, "_data"}, m_data, '0);
    chk({tag, "_busy"},  int'(busy), 0);
  endtask

  // One clock: sample at negedge, check invariants and beats, then model the FIFO read.
  task automatic cyc();
    @(negedge clk);
    cur_cyc++;
    s_req = burst_req; s_len = burst_len; s_rd_en = fifo_rd_en; s_valid = m_valid;
    s_last = m_last; s_data = m_data; s_busy = busy; s_pop = m_valid && m_ready;
    if (s_rd_en) begin
      chk("rd_while_empty", int'(fifo_rd_empty), 0);
      chk("rd_space", int'((rd_total - pop_total - int'(s_pop)) < 2), 1);
      rd_total++;
    end
    if (prev_stall) begin
      chk("stall_valid", int'(s_valid), 1);
      chk_w("stall_data", s_data, prev_data);
      chk("stall_last", int'(s_last), int'(prev_last));
    end
    prev_stall = s_valid && !m_ready;
    prev_data = s_data;
    prev_last = s_last;
    if (s_pop) begin
      if (expq.size() == 0) fail_now("extra_beat");
      else chk_w("beat_data", s_data, expq.pop_front());
      chk("beat_last", int'(s_last), int'(beat_idx == cur_len - 1));
      beat_idx++;
      pop_total++;
    end
    @(posedge clk);
    #1;
    if (s_rd_en && q.size() > 0) fifo_rd_data = q.pop_front();
    update_if();
  endtask

  task automatic run_burst(input int exp_len, input int mode, input int stall_at, input int gap_ref);
    int w, k, rb, ack_c, first_v, first_p, stall_left;
    logic done, stall_done;
    w = 0;
    cyc();
    while (!s_req && w < 60) begin cyc(); w++; end
    if (!s_req) begin fail_now("req_timeout"); return; end
    req_c = cur_cyc;
    if (gap_ref >= 0) chk("req_gap", req_c, gap_ref + 2);
    chk("burst_len", int'(s_len), exp_len);
    rb = rd_total;
    cyc(); cyc();
    chk("req_hold", int'(s_req), 1);
    chk("len_hold", int'(s_len), exp_len);
    burst_ack = 1'b1;
    cyc();
    burst_ack = 1'b0;
    ack_c = cur_cyc;
    chk("no_rd_in_req", rd_total - rb, 0);
    cur_len = exp_len; beat_idx = 0; first_v = -1; first_p = -1;
    done = 1'b0; stall_done = 1'b0; stall_left = 0; k = 0;
    while (!done && k < 400) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (k % 2 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) force_empty = 1'b0;
      end else if (stall_at >= 0 && !stall_done && (rd_total - rb) == stall_at) begin
        force_empty = 1'b1; stall_left = 4; stall_done = 1'b1;
      end
      update_if();
      cyc();
      k++;
      if (s_valid && first_v < 0) first_v = cur_cyc;
      if (s_pop && first_p < 0) first_p = cur_cyc;
      if (s_pop && s_last) begin done = 1'b1; last_pop_c = cur_cyc; end
    end
    m_ready = 1'b1;
    force_empty = 1'b0;
    update_if();
    if (!done) begin fail_now("burst_timeout"); return; end
    chk("beats", beat_idx, exp_len);
    chk("reads", rd_total - rb, exp_len);
    if (mode == 0 && stall_at < 0) begin
      chk("first_valid_lat", first_v, ack_c + 3);
      chk("back_to_back", last_pop_c - first_p, exp_len - 1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int reqs, rds;
    tbl[0] = '{n: 16, fl: 1'b0, mode: 0, exp_len: 16};
    tbl[1] = '{n: 16, fl: 1'b0, mode: 1, exp_len: 16};
    tbl[2] = '{n: 16, fl: 1'b0, mode: 2, exp_len: 16};
    tbl[3] = '{n: 5,  fl: 1'b1, mode: 0, exp_len: 5};
    tbl[4] = '{n: 3,  fl: 1'b1, mode: 2, exp_len: 3};

    tb_rst = 1'b1; flush = 1'b0; burst_ack = 1'b0; m_ready = 1'b1;
    force_empty = 1'b0; fifo_rd_data = '0;
    update_if();
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outs("rst_init");
    tb_rst = 1'b0;

    // Grant pulse while idle must be ignored.
    burst_ack = 1'b1;
    cyc();
    burst_ack = 1'b0;
    cyc(); cyc();
    chk("ack_idle_busy", int'(s_busy), 0);
    chk("ack_idle_req", int'(s_req), 0);

    for (int i = 0; i < 5; i++) begin
      flush = tbl[i].fl;
      preload(tbl[i].n);
      run_burst(tbl[i].exp_len, tbl[i].mode, -1, -1);
      flush = 1'b0;
    end

    // Flush with nothing buffered: no request.
    flush = 1'b1;
    reqs = 0;
    repeat (8) begin cyc(); if (s_req) reqs++; end
    chk("flush_empty_noreq", reqs, 0);
    flush = 1'b0;

    // Multi-burst: 40 words -> two back-to-back 16s, 8 left, then flushed.
    preload(40);
    run_burst(16, 0, -1, -1);
    run_burst(16, 0, -1, last_pop_c);
    reqs = 0;
    repeat (10) begin cyc(); if (s_req) reqs++; end
    chk("residue_noreq", reqs, 0);
    chk("residue_level", int'(fifo_rd_water_level), 8);
    flush = 1'b1;
    run_burst(8, 0, -1, -1);
    flush = 1'b0;

    // Empty flag pulses for 4 cycles after 6 reads.
    preload(16);
    run_burst(16, 0, 6, -1);

    // Reset mid-burst.
    preload(16);
    reqs = 0;
    cyc();
    while (!s_req && reqs < 60) begin cyc(); reqs++; end
    if (!s_req) fail_now("rst_req_timeout");
    burst_ack = 1'b1;
    cyc();
    burst_ack = 1'b0;
    repeat (5) cyc();
    chk("busy_before_rst", int'(busy), 1);
    tb_rst = 1'b1;
    #1;
    chk_zero_outs("rst_mid");
    @(posedge clk);
    @(posedge clk);
    #1;
    tb_rst = 1'b0;
    q.delete(); expq.delete();
    rd_total = 0; pop_total = 0; beat_idx = 0; prev_stall = 1'b0;
    update_if();
    preload(5);
    reqs = 0; rds = 0;
    repeat (12) begin cyc(); if (s_req) reqs++; if (s_rd_en) rds++; end
    chk("post_rst_noreq", reqs, 0);
    chk("post_rst_nord", rds, 0);
    chk("post_rst_idle", int'(s_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcie_fifo_burst_reader.md
Name: pcie_fifo_burst_reader

Overview:
Read-side controller for the 16-to-128-bit asynchronous pcie_fifo. It monitors the FIFO read water level and requests a burst from the downstream PCIe DMA engine. Once the burst is granted, it drains exactly the granted number of 128-bit words onto a valid/ready stream and marks the final beat. It sits in the rd_clk domain, between pcie_fifo and the DMA TX engine.

Parameters:
DATA_WIDTH, 128, FIFO read word width and stream width
LEVEL_WIDTH, 10, width of FIFO rd_water_level (RD_DEPTH_WIDTH+1)
BURST_LEN, 16, maximum words per burst (1..255)
LEN_WIDTH, 8, width of burst_len

Ports:
clk  in  1  read-side clock, rising edge
tb_rst  in  1  reset, asynchronous, active-high
fifo_rd_data  in  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en (no output reg)
fifo_rd_empty  in  1  FIFO empty flag
fifo_rd_water_level  in  LEVEL_WIDTH  words currently readable
fifo_rd_en  out  1  FIFO read strobe
flush  in  1  level: permit a partial burst when fewer than BURST_LEN words remain
burst_req  out  1  burst request to DMA
burst_len  out  LEN_WIDTH  words in requested burst, stable while burst_req=1
burst_ack  in  1  DMA grant, one-cycle pulse
m_data  out  DATA_WIDTH  stream data
m_valid  out  1  stream valid
m_ready  in  1  stream ready
m_last  out  1  final beat of burst
busy  out  1  high in REQ or XFER

Behaviour:
- Reset values: fifo_rd_en=0, burst_req=0, burst_len=0, m_valid=0, m_last=0, m_data=0, busy=0. State=IDLE; all counters and the skid buffer are cleared. Reset mid-burst aborts immediately; there is no resume.
- States: IDLE, REQ, XFER.
- IDLE:
  - If level >= BURST_LEN: go to REQ, latch len=BURST_LEN.
  - Else if flush=1 and level != 0: go to REQ, latch len=level.
  - Else stay in IDLE.
  - The full-burst check has priority over flush.
- REQ: burst_req=1, burst_len=len; no FIFO reads. On burst_ack=1, go to XFER the next cycle. burst_ack received outside REQ is ignored.
- XFER:
  - rd_cnt counts issued reads; beat_cnt counts accepted beats.
  - fifo_rd_en = (rd_cnt < len) && !fifo_rd_empty && (buf_cnt + inflight - pop < 2).
  - inflight = fifo_rd_en registered; pop = m_valid && m_ready.
  - Read data is captured into a 2-entry skid FIFO on the cycle after fifo_rd_en.
  - m_valid = buf_cnt != 0; m_data = buffer head.
  - m_last = m_valid && (beat_cnt == len-1).
  - When pop occurs with m_last=1: return to IDLE next cycle; rd_cnt and beat_cnt clear.
- Latency: first fifo_rd_en in the first XFER cycle; first m_valid 2 cycles later. With m_ready held at 1, beats are back-to-back (1/cycle).
- Boundaries:
  - Never reads when fifo_rd_empty=1; reads stall and resume when data arrives.
  - Never issues more than len reads per burst.
  - Skid buffer never exceeds 2 entries; no beat is dropped or duplicated under any m_ready pattern.
  - m_data and m_last hold stable while m_valid=1 && m_ready=0.
  - A simultaneous capture and pop keeps buf_cnt unchanged.
  - A new burst can be requested in the cycle after the last beat leaves (IDLE re-evaluates immediately).
  - Flush dropping while in REQ/XFER has no effect; the latched len stands.

Test Plan:
- Reset: assert tb_rst mid-operation -> all outputs 0 within the same cycle; IDLE after release; no fifo_rd_en for level < BURST_LEN and flush=0.
- Full burst: preload 16 words (0x...F..FF down-count pattern), level=16; ack 3 cycles after burst_req; m_ready=1 -> burst_len=16; exactly 16 fifo_rd_en pulses; 16 consecutive beats in FIFO order; m_last only on beat 16.
- Backpressure: same burst with m_ready toggling 1,0,1,0 and random stalls -> 16 beats, data order intact, no duplicates; m_data stable during stalls; fifo_rd_en never asserted with 2 buffered plus 1 inflight.
- Flush: level=5, flush=1 -> burst_len=5, 5 beats, m_last on 5th; level=0 with flush=1 -> no burst_req.
- Multi-burst: level=40, flush=0 -> two bursts of 16 back-to-back, then IDLE with 8 words left; raising flush -> a third burst of len 8.
- Empty stall: level reports 16 but fifo_rd_empty pulses high for 4 cycles mid-burst -> fifo_rd_en held low during the empty pulse; burst completes with 16 correct beats.
